// File: rtl/scope_pkg.sv
// Shared types and constants for the scope capture sequencer and its trigger detector.
package scope_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        HOLD  = 3'd4
    } cap_state_t;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_SINGLE = 2'd2,
        MODE_RSVD   = 2'd3
    } trig_mode_t;

    localparam logic [1:0] CH_A0 = 2'd0;
    localparam logic [1:0] CH_A1 = 2'd1;
    localparam logic [1:0] CH_B0 = 2'd2;
    localparam logic [1:0] CH_B1 = 2'd3;

    // Shared sample counter width; wide enough for PRE_TRIG, WIN and AUTO_TO.
    localparam int CNT_W = 16;

endpackage

// File: rtl/scope_trig_detect.sv
// Selects the trigger channel, remembers the previous sample and flags a level crossing
// on the current sample strobe.
module scope_trig_detect
    import scope_pkg::*;
#(
    parameter int AD_W = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sample_stb,
    input  logic [AD_W-1:0] ad_a0,
    input  logic [AD_W-1:0] ad_a1,
    input  logic [AD_W-1:0] ad_b0,
    input  logic [AD_W-1:0] ad_b1,
    input  logic [1:0]      trig_sel,
    input  logic [AD_W-1:0] trig_level,
    input  logic            trig_rising,
    output logic            crossing
);

    logic [AD_W-1:0] cur;
    logic [AD_W-1:0] prev_q;
    logic            prev_valid_q;
    logic            rise;
    logic            fall;

    always_comb begin
        case (trig_sel)
            CH_A0:   cur = ad_a0;
            CH_A1:   cur = ad_a1;
            CH_B0:   cur = ad_b0;
            default: cur = ad_b1;
        endcase
    end

    assign rise     = (prev_q < trig_level) && (cur >= trig_level);
    assign fall     = (prev_q >= trig_level) && (cur < trig_level);
    assign crossing = sample_stb && prev_valid_q && (trig_rising ? rise : fall);

    // History follows the currently selected channel in every capture state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else if (sample_stb) begin
            prev_q       <= cur;
            prev_valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/scope_capture_ctrl.sv
// Trigger/capture sequencer for the scope sample RAMs: drives the RAM write port,
// positions the display window around the trigger and freezes it until a frame is shown.
module scope_capture_ctrl
    import scope_pkg::*;
#(
    parameter int AD_W     = 12,
    parameter int ADDR_W   = 10,
    parameter int WIN      = 640,
    parameter int PRE_TRIG = 320,
    parameter int AUTO_TO  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_stb,
    input  logic [AD_W-1:0]   ad_a0,
    input  logic [AD_W-1:0]   ad_a1,
    input  logic [AD_W-1:0]   ad_b0,
    input  logic [AD_W-1:0]   ad_b1,
    input  logic [1:0]        trig_sel,
    input  logic [AD_W-1:0]   trig_level,
    input  logic              trig_rising,
    input  logic [1:0]        mode,
    input  logic              arm,
    input  logic              frame_end,
    output logic              we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] disp_base,
    output logic              cap_valid,
    output logic              triggered,
    output logic [2:0]        state
);

    localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(PRE_TRIG);
    localparam logic [CNT_W-1:0] POST_CNT = CNT_W'(WIN - PRE_TRIG);
    localparam logic [CNT_W-1:0] AUTO_CNT = CNT_W'(AUTO_TO);
    localparam cap_state_t       FILL_STATE = (PRE_TRIG == 0) ? ARMED : PRE;

    cap_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] disp_base_q, disp_base_d;
    logic              cap_valid_q, cap_valid_d;
    logic              triggered_q, triggered_d;

    trig_mode_t        trig_mode;
    logic              crossing;
    logic              writing;
    logic              fire;
    logic [CNT_W-1:0]  cnt_inc;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] trig_base;

    scope_trig_detect #(
        .AD_W (AD_W)
    ) u_trig (
        .clk         (clk),
        .reset       (reset),
        .sample_stb  (sample_stb),
        .ad_a0       (ad_a0),
        .ad_a1       (ad_a1),
        .ad_b0       (ad_b0),
        .ad_b1       (ad_b1),
        .trig_sel    (trig_sel),
        .trig_level  (trig_level),
        .trig_rising (trig_rising),
        .crossing    (crossing)
    );

    assign trig_mode = trig_mode_t'(mode);
    assign writing   = sample_stb && (state_q inside {PRE, ARMED, POST});
    assign cnt_inc   = cnt_q + 1'b1;
    // The sample on this strobe lands at wr_addr+1; the window starts PRE_TRIG before it.
    assign addr_inc  = wr_addr_q + 1'b1;
    assign trig_base = addr_inc - ADDR_W'(PRE_TRIG);
    assign fire      = crossing || ((trig_mode == MODE_AUTO) && (cnt_inc == AUTO_CNT));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        disp_base_d = disp_base_q;
        cap_valid_d = cap_valid_q;
        triggered_d = triggered_q;
        case (state_q)
            IDLE: begin
                if (arm || (trig_mode != MODE_SINGLE)) begin
                    state_d = FILL_STATE;
                    cnt_d   = '0;
                end
            end
            PRE: begin
                if (sample_stb) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == PRE_CNT) begin
                        state_d = ARMED;
                        cnt_d   = '0;
                    end
                end
            end
            ARMED: begin
                if (sample_stb) begin
                    if (fire) begin
                        disp_base_d = trig_base;
                        triggered_d = crossing;
                        cnt_d       = CNT_W'(1);
                        if (POST_CNT == CNT_W'(1)) begin
                            state_d     = HOLD;
                            cap_valid_d = 1'b1;
                        end else begin
                            state_d = POST;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            POST: begin
                if (sample_stb) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == POST_CNT) begin
                        state_d     = HOLD;
                        cap_valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (frame_end) begin
                    cap_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = (trig_mode == MODE_SINGLE) ? IDLE : FILL_STATE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            wr_addr_q   <= '1;
            disp_base_q <= '0;
            cap_valid_q <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= writing;
            disp_base_q <= disp_base_d;
            cap_valid_q <= cap_valid_d;
            triggered_q <= triggered_d;
            if (writing) begin
                wr_addr_q <= addr_inc;
            end
        end
    end

    assign we        = we_q;
    assign wr_addr   = wr_addr_q;
    assign disp_base = disp_base_q;
    assign cap_valid = cap_valid_q;
    assign triggered = triggered_q;
    assign state     = state_q;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Scoreboard bench for scope_capture_ctrl: stimulus queues expected write addresses and
// capture results; a negedge monitor pops and compares whenever the DUT writes or captures.
module tb_scope_capture_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_stb = 1'b0;
    logic [11:0] ad_a0 = '0;
    logic [11:0] ad_a1 = '0;
    logic [11:0] ad_b0 = '0;
    logic [11:0] ad_b1 = '0;
    logic [1:0]  trig_sel = 2'd0;
    logic [11:0] trig_level = 12'd2048;
    logic        trig_rising = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        arm = 1'b0;
    logic        frame_end = 1'b0;
    logic        we;
    logic [9:0]  wr_addr;
    logic [9:0]  disp_base;
    logic        cap_valid;
    logic        triggered;
    logic [2:0]  state;

    typedef struct {
        logic [31:0] base;
        logic        trig;
    } cap_t;

    int          checks = 0;
    int          errors = 0;
    int          expAddr = 1023;
    logic [31:0] wq[$];
    cap_t        cq[$];
    logic        capPrev = 1'b0;

    scope_capture_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .sample_stb  (sample_stb),
        .ad_a0       (ad_a0),
        .ad_a1       (ad_a1),
        .ad_b0       (ad_b0),
        .ad_b1       (ad_b1),
        .trig_sel    (trig_sel),
        .trig_level  (trig_level),
        .trig_rising (trig_rising),
        .mode        (mode),
        .arm         (arm),
        .frame_end   (frame_end),
        .we          (we),
        .wr_addr     (wr_addr),
        .disp_base   (disp_base),
        .cap_valid   (cap_valid),
        .triggered   (triggered),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Monitor: each RAM write and each capture completion consumes one queued expectation.
    always @(negedge clk) begin
        logic [31:0] e;
        cap_t        c;
        if (!reset) begin
            if (we) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL write_addr: unexpected write at %0d, required no write", wr_addr);
                end else begin
                    e = wq.pop_front();
                    if (32'(wr_addr) !== e) begin
                        errors++;
                        $display("[TB] FAIL write_addr: got %0d required %0d", wr_addr, e);
                    end
                end
            end
            if (cap_valid && !capPrev) begin
                checks++;
                if (cq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL capture: unexpected capture base %0d, required none", disp_base);
                end else begin
                    c = cq.pop_front();
                    if (32'(disp_base) !== c.base || triggered !== c.trig || state !== 3'd4) begin
                        errors++;
                        $display("[TB] FAIL capture: got base %0d trig %0b state %0d required base %0d trig %0b state 4",
                                 disp_base, triggered, state, c.base, c.trig);
                    end
                end
            end
        end
        capPrev = cap_valid;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
        end
    endtask

    task automatic checkDrained(input string name);
        checkOutput({name, "_writes_left"}, 32'(wq.size()), 32'd0);
        checkOutput({name, "_captures_left"}, 32'(cq.size()), 32'd0);
    endtask

    // One strobe (optionally with arm), then one idle cycle.
    task automatic applyStimulus(input logic expectWrite, input logic withArm);
        sample_stb = 1'b1;
        arm        = withArm;
        @(posedge clk); #1;
        sample_stb = 1'b0;
        arm        = 1'b0;
        if (expectWrite) begin
            expAddr = (expAddr + 1) % 1024;
            wq.push_back(32'(expAddr));
        end
        @(posedge clk); #1;
    endtask

    task automatic doReset(input logic [1:0] m);
        mode       = m;
        sample_stb = 1'b0;
        arm        = 1'b0;
        frame_end  = 1'b0;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        expAddr = 1023;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic pulseFrameEnd();
        frame_end = 1'b1;
        @(posedge clk); #1;
        frame_end = 1'b0;
    endtask

    function automatic logic [11:0] rampVal(input int k);
        return 12'((16 * k) % 4096);
    endfunction

    initial begin
        #12;
        checkOutput("rst_we", 32'(we), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd1023);
        checkOutput("rst_disp_base", 32'(disp_base), 32'd0);
        checkOutput("rst_cap_valid", 32'(cap_valid), 32'd0);
        checkOutput("rst_triggered", 32'(triggered), 32'd0);
        checkOutput("rst_state", 32'(state), 32'd0);

        // NORMAL rising ramp: PRE k=0..319, crossing at k=384 (addr 384), window 64..703.
        trig_sel = 2'd0; trig_level = 12'd2048; trig_rising = 1'b1;
        doReset(2'd0);
        checkOutput("t1_auto_armed", 32'(state), 32'd1);
        cq.push_back('{32'd64, 1'b1});
        for (int k = 0; k < 704; k++) begin
            ad_a0 = rampVal(k);
            applyStimulus(1'b1, 1'b0);
        end
        checkOutput("t1_hold", 32'(state), 32'd4);
        checkOutput("t1_cap_valid", 32'(cap_valid), 32'd1);
        for (int k = 704; k < 707; k++) begin
            ad_a0 = rampVal(k);
            applyStimulus(1'b0, 1'b0);
        end
        pulseFrameEnd();
        checkOutput("t1_release_cap", 32'(cap_valid), 32'd0);
        checkOutput("t1_rearm_pre", 32'(state), 32'd1);
        checkDrained("t1");

        // Re-arm continues at addr 704; ARMED starts after wrap at addr 0, crossing k=1152 at addr 125.
        cq.push_back('{32'd829, 1'b1});
        for (int k = 707; k < 1472; k++) begin
            ad_a0 = rampVal(k);
            applyStimulus(1'b1, 1'b0);
        end
        checkOutput("t4_hold", 32'(state), 32'd4);
        checkDrained("t4");

        // Falling on a1 square; a0 in antiphase would trigger at k=320 if selected wrongly.
        trig_sel = 2'd1; trig_level = 12'd1000; trig_rising = 1'b0;
        doReset(2'd0);
        cq.push_back('{32'd8, 1'b1});
        for (int k = 0; k < 650; k++) begin
            ad_a1 = ((k / 8) % 2 == 0) ? 12'd4095 : 12'd0;
            ad_a0 = ((k / 8) % 2 == 0) ? 12'd0 : 12'd4095;
            applyStimulus(k < 648, 1'b0);
        end
        checkOutput("t2_hold", 32'(state), 32'd4);
        checkOutput("t2_triggered", 32'(triggered), 32'd1);
        checkDrained("t2");

        // AUTO with flat input: 1024th ARMED sample (k=1343, addr 319) forces the trigger.
        ad_a0 = 12'd100; ad_a1 = 12'd100; ad_b0 = 12'd100; ad_b1 = 12'd100;
        trig_sel = 2'd0; trig_level = 12'd2048; trig_rising = 1'b1;
        doReset(2'd1);
        cq.push_back('{32'd1023, 1'b0});
        for (int k = 0; k < 1663; k++) begin
            applyStimulus(1'b1, 1'b0);
        end
        checkOutput("t3_auto_hold", 32'(state), 32'd4);
        checkOutput("t3_auto_triggered", 32'(triggered), 32'd0);
        checkDrained("t3_auto");

        doReset(2'd0);
        for (int k = 0; k < 1420; k++) begin
            applyStimulus(1'b1, 1'b0);
        end
        checkOutput("t3_normal_armed", 32'(state), 32'd2);
        checkOutput("t3_normal_cap", 32'(cap_valid), 32'd0);
        checkDrained("t3_normal");

        // SINGLE: idle until arm; arm+stb sample j=3 is not written; crossing j=384 at addr 380.
        doReset(2'd2);
        checkOutput("t5_idle", 32'(state), 32'd0);
        for (int j = 0; j < 3; j++) begin
            ad_a0 = rampVal(j);
            applyStimulus(1'b0, 1'b0);
        end
        checkOutput("t5_still_idle", 32'(state), 32'd0);
        ad_a0 = rampVal(3);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t5_armed_pre", 32'(state), 32'd1);
        cq.push_back('{32'd60, 1'b1});
        for (int j = 4; j < 704; j++) begin
            ad_a0 = rampVal(j);
            applyStimulus(1'b1, 1'b0);
        end
        checkOutput("t5_hold", 32'(state), 32'd4);
        pulseFrameEnd();
        checkOutput("t5_back_idle", 32'(state), 32'd0);
        checkOutput("t5_cap_clear", 32'(cap_valid), 32'd0);
        for (int j = 704; j < 706; j++) begin
            ad_a0 = rampVal(j);
            applyStimulus(1'b0, 1'b0);
        end
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        checkOutput("t5_rearm", 32'(state), 32'd1);
        ad_a0 = rampVal(706);
        applyStimulus(1'b1, 1'b0);
        checkDrained("t5");

        // Reset in POST between clock edges while a write is in flight.
        doReset(2'd0);
        for (int k = 0; k < 400; k++) begin
            ad_a0 = rampVal(k);
            applyStimulus(1'b1, 1'b0);
        end
        checkOutput("t6_post", 32'(state), 32'd3);
        checkOutput("t6_trig_before", 32'(triggered), 32'd1);
        ad_a0 = rampVal(400);
        sample_stb = 1'b1;
        @(posedge clk); #1;
        sample_stb = 1'b0;
        checkOutput("t6_we_before", 32'(we), 32'd1);
        checkOutput("t6_addr_before", 32'(wr_addr), 32'd400);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("t6_we", 32'(we), 32'd0);
        checkOutput("t6_cap_valid", 32'(cap_valid), 32'd0);
        checkOutput("t6_state", 32'(state), 32'd0);
        checkOutput("t6_wr_addr", 32'(wr_addr), 32'd1023);
        checkOutput("t6_triggered", 32'(triggered), 32'd0);
        checkOutput("t6_disp_base", 32'(disp_base), 32'd0);
        @(posedge clk); #1;
        checkDrained("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
